ch_serializer: RTL

CH_SERIALIZER -- requirements
Module: ch_serializer

---
 rtl/ch_serializer.sv | 110 +++++++++++
 1 files changed

// File: rtl/ch_serializer.sv
// Pixel-to-beat serializer: buffers whole pixels and emits BEATS beats of LANES channels each.
// Latency: a pixel pushed into an empty FIFO at cycle N shows beat 0 at cycle N+1. Backpressure: outputs hold while dout_rdy=0.
// Upstream cannot be stalled: pixels arriving when full are dropped. CH_SERIALIZER_OVF_EN enables the sticky overflow flag.
module ch_serializer #(
  parameter int CH_NUM     = 128,
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 fin_start,
  input  logic                                 din_vld,
  input  logic [CH_NUM-1:0][DATA_WIDTH-1:0]    din,
  input  logic                                 dout_rdy,
  output logic                                 dout_vld,
  output logic [LANES-1:0][DATA_WIDTH-1:0]     dout,
  output logic                                 fout_start,
  output logic                                 dout_last,
  output logic                                 overflow
);

  localparam int BEATS = CH_NUM / LANES;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int PW    = AW + 1;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef logic [CH_NUM-1:0][DATA_WIDTH-1:0] pixel_t;
  typedef logic [LANES-1:0][DATA_WIDTH-1:0]  beat_t;

  generate
    if ((CH_NUM % LANES) != 0) begin : g_bad_lanes
      $error("CH_NUM must be a multiple of LANES");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of two >= 2");
    end
  endgenerate

  pixel_t                mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] tag_mem;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [BW-1:0]         beat_cnt;
  logic                  start_pend;

  logic   empty, full, last_beat, accept, pop, push, start_eff, head_tag;
  pixel_t head;
  beat_t  beat_words [BEATS];

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign last_beat = (beat_cnt == BW'(BEATS - 1));
  assign dout_vld  = !empty;
  assign accept    = dout_vld && dout_rdy;
  assign pop       = accept && last_beat;
  // A full FIFO still takes a pixel when the head's last beat leaves on the same edge.
  assign push      = din_vld && (!full || pop);
  // A second fin_start before any push cancels the pending tag rather than queueing it.
  assign start_eff = start_pend ^ fin_start;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      beat_cnt   <= '0;
      start_pend <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (accept) beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
      start_pend <= push ? 1'b0 : start_eff;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]]     <= din;
      tag_mem[wr_ptr[AW-1:0]] <= start_eff;
    end
  end

  assign head     = mem[rd_ptr[AW-1:0]];
  assign head_tag = tag_mem[rd_ptr[AW-1:0]];

  for (genvar b = 0; b < BEATS; b++) begin : g_beat
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign beat_words[b][l] = head[b*LANES + l];
    end
  end

  // Gated so that stale FIFO contents never leak out while empty or in reset.
  assign dout       = dout_vld ? beat_words[beat_cnt] : '0;
  assign fout_start = dout_vld && head_tag && (beat_cnt == '0);
  assign dout_last  = dout_vld && last_beat;

`ifdef CH_SERIALIZER_OVF_EN
  logic drop;
  assign drop = din_vld && !push;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       overflow <= 1'b0;
    else if (drop)      overflow <= 1'b1;
    else if (fin_start) overflow <= 1'b0;
  end
`else
  assign overflow = 1'b0;
`endif

endmodule
